// File: rtl/prog_loader.sv
// Boot loader: byte stream in, big-endian words out to instruction/data memory.
// Holds the core stalled until the whole image has been written.
module prog_loader #(
  parameter int WORD   = 32,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              stall_o,
  output logic              mem_write,
  output logic [WORD-1:0]   mem_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**ADDR_W);

  state_t            state, nxt;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_full;
  logic [1:0]        byte_cnt;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   word_nxt;
  logic              xfer;

  assign xfer     = rx_valid & rx_ready;
  assign len_full = {len[LEN_W-1:8], rx_data};
  assign word_nxt = word_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    rx_ready  = 1'b0;
    stall_o   = 1'b0;
    mem_write = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nxt = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        stall_o  = 1'b1;
        if (xfer) nxt = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        stall_o  = 1'b1;
        if (xfer) begin
          if (len_full == '0)         nxt = DONE;
          else if (len_full > MAX_LEN) nxt = ERR;
          else                        nxt = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        stall_o  = 1'b1;
        if (xfer && byte_cnt == 2'd3) nxt = WRITE;
      end
      WRITE: begin
        stall_o   = 1'b1;
        mem_write = 1'b1;
        if (LEN_W'(word_nxt) == len) nxt = DONE;
        else                         nxt = DATA;
      end
      DONE:    nxt = IDLE;
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len      <= '0;
      byte_cnt <= '0;
      word_cnt <= '0;
      mem_in   <= '0;
      mem_addr <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        done     <= 1'b0;
        err      <= 1'b0;
        mem_addr <= '0;
        word_cnt <= '0;
        byte_cnt <= '0;
      end
      if (state == LEN_HI && xfer) len[LEN_W-1:8] <= rx_data;
      if (state == LEN_LO && xfer) len[7:0] <= rx_data;
      if (state == DATA && xfer) begin
        mem_in   <= {mem_in[WORD-9:0], rx_data};
        byte_cnt <= byte_cnt + 2'd1;
      end
      // Address wraps only after the final word since N <= 2**ADDR_W
      if (state == WRITE) begin
        mem_addr <= mem_addr + 1'b1;
        word_cnt <= word_nxt;
      end
      if (nxt == DONE) done <= 1'b1;
      if (nxt == ERR)  err  <= 1'b1;
    end
  end

endmodule
